// File: rtl/event_flag_reader_if.sv
// Handshake and flag-bank signals between event producers/consumer and event_flag_reader.
// The master side drives the set/mask/ready/clear lines; the slave side is the flag bank.
interface event_flag_reader_if #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
);
    logic [WIDTH-1:0] set_IN;
    logic [WIDTH-1:0] mask_IN;
    logic             ready_IN;
    logic             clr_ovf_IN;
    logic             valid_OUT;
    logic [IDX_W-1:0] idx_OUT;
    logic [WIDTH-1:0] pending_OUT;
    logic [WIDTH-1:0] overflow_OUT;

    modport master (
        output set_IN,
        output mask_IN,
        output ready_IN,
        output clr_ovf_IN,
        input  valid_OUT,
        input  idx_OUT,
        input  pending_OUT,
        input  overflow_OUT
    );

    modport slave (
        input  set_IN,
        input  mask_IN,
        input  ready_IN,
        input  clr_ovf_IN,
        output valid_OUT,
        output idx_OUT,
        output pending_OUT,
        output overflow_OUT
    );
endinterface

// File: rtl/event_flag_reader.sv
// Sticky event-flag bank that offers the lowest pending, unmasked flag over valid/ready
// and clears it on acceptance.
//
// state | meaning
// IDLE  | no offer outstanding; loads lowest (pending & mask) index when one exists
// OFFER | idx_OUT held stable until ready_IN accepts it
module event_flag_reader #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input logic              clk,
    input logic              rst,
    event_flag_reader_if.slave bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] pending;
    logic [WIDTH-1:0] overflow;
    logic [IDX_W-1:0] idx;
    logic             valid;

    logic [WIDTH-1:0] masked;
    logic [WIDTH-1:0] clr_vec;
    logic [WIDTH-1:0] ovf_evt;
    logic [WIDTH-1:0] pending_nxt;
    logic [WIDTH-1:0] overflow_nxt;
    logic [IDX_W-1:0] low_idx;
    logic             any_req;
    logic             accept;

    assign masked  = pending & bus.mask_IN;
    assign any_req = |masked;
    assign accept  = (state == OFFER) && bus.ready_IN;

    // Scan downward so the last hit written is the lowest set index.
    always_comb begin
        low_idx = '0;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (masked[i]) begin
                low_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        clr_vec = '0;
        if (accept) begin
            clr_vec[idx] = 1'b1;
        end
    end

    // A set landing on a bit being cleared re-arms it instead of counting as overflow.
    assign ovf_evt      = bus.set_IN & pending & ~clr_vec;
    assign pending_nxt  = (pending & ~clr_vec) | bus.set_IN;
    assign overflow_nxt = (bus.clr_ovf_IN ? '0 : overflow) | ovf_evt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            pending  <= '0;
            overflow <= '0;
            idx      <= '0;
            valid    <= 1'b0;
        end else begin
            pending  <= pending_nxt;
            overflow <= overflow_nxt;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        idx   <= low_idx;
                        valid <= 1'b1;
                        state <= OFFER;
                    end
                end
                OFFER: begin
                    if (bus.ready_IN) begin
                        valid <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.valid_OUT    = valid;
    assign bus.idx_OUT      = idx;
    assign bus.pending_OUT  = pending;
    assign bus.overflow_OUT = overflow;

endmodule

// File: tb/tb_event_flag_reader.sv
// Directed bench for event_flag_reader: expected offer indices go into a queue when the
// flags are set and are popped when the DUT presents an offer.
module tb_event_flag_reader;

    localparam int WIDTH = 8;
    localparam int IDX_W = 3;

    logic clk;
    logic rst;

    event_flag_reader_if #(.WIDTH(WIDTH), .IDX_W(IDX_W)) bus ();

    event_flag_reader #(.WIDTH(WIDTH), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_offer(input string tag);
        int e;
        chk({tag, "_valid"}, {31'd0, bus.valid_OUT}, 32'd1);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $error("FAIL %s_queue: observed offer %0d expected none", tag, bus.idx_OUT);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_idx"}, {29'd0, bus.idx_OUT}, e);
        end
    endtask

    initial begin
        logic [WIDTH-1:0] exp_pend;

        rst            = 1'b0;
        bus.set_IN     = '0;
        bus.mask_IN    = 8'hFF;
        bus.ready_IN   = 1'b0;
        bus.clr_ovf_IN = 1'b0;

        // Reset held with set lines toggling.
        for (int i = 0; i < 4; i++) begin
            bus.set_IN = (i % 2 == 0) ? 8'hFF : 8'h00;
            tick();
            chk("rst_valid", {31'd0, bus.valid_OUT}, 32'd0);
            chk("rst_pend", {24'd0, bus.pending_OUT}, 32'd0);
            chk("rst_ovf", {24'd0, bus.overflow_OUT}, 32'd0);
        end
        bus.set_IN = '0;
        rst        = 1'b1;
        tick();

        // Basic set-to-offer latency and acceptance.
        bus.set_IN = 8'h04;
        exp_q.push_back(2);
        tick();
        chk("lat_pend", {24'd0, bus.pending_OUT}, 32'h04);
        chk("lat_valid0", {31'd0, bus.valid_OUT}, 32'd0);
        bus.set_IN = '0;
        tick();
        chk_offer("lat_offer");
        bus.ready_IN = 1'b1;
        tick();
        chk("acc_pend", {24'd0, bus.pending_OUT}, 32'h00);
        chk("acc_valid", {31'd0, bus.valid_OUT}, 32'd0);
        bus.ready_IN = 1'b0;

        // Priority: accumulate A0 then 02 while masked, then drain lowest first.
        bus.mask_IN = 8'h00;
        bus.set_IN  = 8'hA0;
        tick();
        bus.set_IN = 8'h02;
        tick();
        bus.set_IN = '0;
        chk("pri_accum", {24'd0, bus.pending_OUT}, 32'hA2);
        exp_q.push_back(1);
        exp_q.push_back(5);
        exp_q.push_back(7);
        exp_pend     = 8'hA2;
        bus.mask_IN  = 8'hFF;
        bus.ready_IN = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int want;
            want = exp_q[0];
            tick();
            chk_offer("pri_offer");
            tick();
            exp_pend[want] = 1'b0;
            chk("pri_gap", {31'd0, bus.valid_OUT}, 32'd0);
            chk("pri_pend", {24'd0, bus.pending_OUT}, {24'd0, exp_pend});
        end
        bus.ready_IN = 1'b0;

        // Masking: bit 0 masked out, offer held while mask drops.
        bus.mask_IN = 8'hFE;
        bus.set_IN  = 8'h03;
        exp_q.push_back(1);
        tick();
        bus.set_IN = '0;
        tick();
        chk_offer("mask_offer");
        bus.mask_IN = 8'h00;
        tick();
        tick();
        chk("mask_hold_valid", {31'd0, bus.valid_OUT}, 32'd1);
        chk("mask_hold_idx", {29'd0, bus.idx_OUT}, 32'd1);
        chk("mask_hold_pend", {24'd0, bus.pending_OUT}, 32'h03);
        bus.ready_IN = 1'b1;
        tick();
        chk("mask_acc_pend", {24'd0, bus.pending_OUT}, 32'h01);
        chk("mask_acc_valid", {31'd0, bus.valid_OUT}, 32'd0);
        bus.ready_IN = 1'b0;
        tick();
        chk("mask_idle", {31'd0, bus.valid_OUT}, 32'd0);
        bus.mask_IN = 8'h01;
        exp_q.push_back(0);
        tick();
        chk_offer("mask_bit0");
        bus.ready_IN = 1'b1;
        tick();
        chk("mask_drain", {24'd0, bus.pending_OUT}, 32'h00);
        bus.ready_IN = 1'b0;

        // Set-wins collision on the accepted bit.
        bus.mask_IN = 8'hFF;
        bus.set_IN  = 8'h08;
        exp_q.push_back(3);
        tick();
        bus.set_IN = '0;
        tick();
        chk_offer("col_offer");
        bus.ready_IN = 1'b1;
        bus.set_IN   = 8'h08;
        exp_q.push_back(3);
        tick();
        chk("col_pend", {24'd0, bus.pending_OUT}, 32'h08);
        chk("col_ovf", {24'd0, bus.overflow_OUT}, 32'h00);
        chk("col_valid", {31'd0, bus.valid_OUT}, 32'd0);
        bus.ready_IN = 1'b0;
        bus.set_IN   = '0;
        tick();
        chk_offer("col_reoffer");
        bus.ready_IN = 1'b1;
        tick();
        chk("col_drain", {24'd0, bus.pending_OUT}, 32'h00);
        bus.ready_IN = 1'b0;

        // Overflow on a masked, already-pending bit.
        bus.mask_IN = 8'hBF;
        bus.set_IN  = 8'h40;
        tick();
        chk("ovf_first", {24'd0, bus.overflow_OUT}, 32'h00);
        tick();
        chk("ovf_raise", {24'd0, bus.overflow_OUT}, 32'h40);
        bus.clr_ovf_IN = 1'b1;
        tick();
        chk("ovf_clr_collide", {24'd0, bus.overflow_OUT}, 32'h40);
        bus.set_IN = '0;
        tick();
        chk("ovf_clr", {24'd0, bus.overflow_OUT}, 32'h00);
        chk("ovf_masked_idle", {31'd0, bus.valid_OUT}, 32'd0);
        bus.clr_ovf_IN = 1'b0;

        // Async reset mid-offer.
        bus.mask_IN = 8'hFF;
        bus.set_IN  = 8'h40;
        exp_q.push_back(6);
        tick();
        bus.set_IN = '0;
        chk_offer("arst_offer");
        chk("arst_pre_ovf", {24'd0, bus.overflow_OUT}, 32'h40);
        #2;
        rst = 1'b0;
        #1;
        chk("arst_valid", {31'd0, bus.valid_OUT}, 32'd0);
        chk("arst_pend", {24'd0, bus.pending_OUT}, 32'h00);
        chk("arst_ovf", {24'd0, bus.overflow_OUT}, 32'h00);
        tick();
        rst = 1'b1;
        tick();
        chk("arst_after", {31'd0, bus.valid_OUT}, 32'd0);
        chk("sb_empty", exp_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: simulation did not finish within bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/event_flag_reader.md
# event_flag_reader

Sticky event-flag bank with a read-side drain port. Producers pulse per-bit set lines. The bits hold like set/reset latches until a consumer takes them. The block offers the lowest-indexed pending, unmasked flag over a valid/ready handshake and clears that flag on acceptance. It sits between processor-side event sources and the control unit that services them.

## Interface
Parameters:
- WIDTH, 8, number of flag bits
- IDX_W, 3, index width; must equal ceil(log2(WIDTH))

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  asynchronous, active-low reset
- set_IN  input  WIDTH  per-bit set request, sampled each rising edge
- mask_IN  input  WIDTH  1 = flag eligible for offering; masked flags still accumulate
- ready_IN  input  1  consumer accepts the offered index this edge
- clr_ovf_IN  input  1  clears all overflow bits
- valid_OUT  output  1  idx_OUT holds an offered flag
- idx_OUT  output  IDX_W  index of the offered flag
- pending_OUT  output  WIDTH  current pending flag register
- overflow_OUT  output  WIDTH  sticky per-bit overflow

## Operation
- Reset (rst low, asynchronous):
  - pending, overflow, idx, valid all go to 0.
  - FSM goes to IDLE.
  - Outputs stay 0 while rst is low.
- Pending update each edge: pending_next = (pending & ~clr_vec) | set_IN.
  - clr_vec is one-hot at idx only on an accepting edge (OFFER & ready_IN); otherwise it is 0.
  - If set and clear coincide on the same bit, set wins: the bit stays pending and no overflow is raised.
- Overflow update:
  - overflow[i] is set when set_IN[i]=1 while pending[i]=1 and bit i is not being cleared that edge.
  - clr_ovf_IN=1 clears all overflow bits. A new overflow event on the same edge wins for its bit.
- FSM has two states:
  - IDLE (valid_OUT=0): on an edge where (pending & mask_IN) != 0, load idx with the lowest set index of (pending & mask_IN), using the register value before the edge. Go to OFFER.
  - OFFER (valid_OUT=1): idx_OUT is held stable. mask_IN changes do not retract or change the offer. On an edge with ready_IN=1, clear pending[idx] (subject to the set-wins rule) and go to IDLE. With ready_IN=0, stay.
- ready_IN is ignored in IDLE.
- Priority is fixed lowest-index-first. There is no round-robin; starvation of high indices under continuous low-index traffic is accepted behaviour.
- Arithmetic: the priority encode is a pure scan from bit 0 to WIDTH-1 with no wrap. Indices never exceed WIDTH-1.

## Timing
- Set-to-offer latency:
  - set_IN sampled at edge N → pending_OUT shows the bit after edge N.
  - valid_OUT rises after edge N+1 when the FSM is in IDLE.
  - If the FSM is in OFFER at edge N, the offer starts one edge after the current offer is accepted.
- Acceptance:
  - The edge with valid_OUT=1 and ready_IN=1 clears the bit. valid_OUT is 0 after that edge.
  - The next offer appears after the following edge, so sustained throughput is 1 flag per 2 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.
- Reset mid-offer drops the offer immediately, asynchronously. No clear handshake completes.
- After rst deasserts, the first possible valid_OUT is 2 edges after the first set_IN sample.

## Test plan
- Reset: rst=0 with set_IN=8'hFF toggling → all outputs stay 0. Release rst, pulse set_IN=8'h04 one cycle → pending_OUT=8'h04 after 1 edge; valid_OUT=1 with idx_OUT=2 after 2 edges. ready_IN=1 for one edge → pending_OUT=0, valid_OUT=0.
- Priority: set_IN=8'hA0, then set_IN=8'h02, mask_IN=8'hFF, ready_IN held 1 → offers appear in the order 1, 5, 7, one every 2 cycles. pending_OUT reaches 0.
- Masking:
  - pending=8'h03, mask_IN=8'hFE → offer idx 1. Bit 0 stays pending.
  - Drop mask_IN to 0 during the offer → idx_OUT stays 1 until accepted.
- Set-wins collision: in OFFER at idx 3, assert ready_IN and set_IN=8'h08 on the same edge → pending[3] stays 1, overflow_OUT=0. Idx 3 is re-offered 1 edge later.
- Overflow:
  - pending[6]=1 (masked), pulse set_IN[6] → overflow_OUT=8'h40.
  - clr_ovf_IN=1 together with set_IN[6] → overflow stays 8'h40.
  - clr_ovf_IN=1 alone → overflow_OUT=0.
- Async reset mid-offer: pull rst low between edges while valid_OUT=1 → valid_OUT, pending_OUT and overflow_OUT drop to 0 without waiting for a clock edge.
